// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped peripheral responder for the single-cycle MIPS core.
// Holds the timer (TH/TL/TCON + IRQ), LEDs, switches, 7-seg digits and the UART
// register file. Reads are combinational; writes land on the next rising edge.
//
// Ports:
//   clk, reset       system clock; asynchronous active-low reset
//   rd, wr           bus read / write strobes
//   addr, wdata      word-aligned byte address, write data
//   rdata            read data (0 when rd=0 or address unmapped)
//   led, switch      LED register out, slide switches in
//   digi             7-seg drive {an[3:0], seg[7:0]}
//   irqout           timer interrupt = TCON[1] & TCON[2]
//   tx_data/start    byte + one-cycle launch pulse to the UART transmitter
//   tx_busy          transmitter shifting
//   rx_data/valid    byte + strobe from the UART receiver
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi,
    output logic        irqout,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam logic [31:0] A_TH    = BASE_ADDR + 32'h00;
    localparam logic [31:0] A_TL    = BASE_ADDR + 32'h04;
    localparam logic [31:0] A_TCON  = BASE_ADDR + 32'h08;
    localparam logic [31:0] A_LED   = BASE_ADDR + 32'h0C;
    localparam logic [31:0] A_SW    = BASE_ADDR + 32'h10;
    localparam logic [31:0] A_DIGI  = BASE_ADDR + 32'h14;
    localparam logic [31:0] A_RXD0  = BASE_ADDR + 32'h18;
    localparam logic [31:0] A_RXD1  = BASE_ADDR + 32'h1C;
    localparam logic [31:0] A_USTAT = BASE_ADDR + 32'h20;
    localparam logic [31:0] A_TXD   = BASE_ADDR + 32'h24;
    localparam logic [31:0] A_UCON  = BASE_ADDR + 32'h28;

    logic [31:0] th, tl;
    logic [2:0]  tcon;
    logic [7:0]  rxd0, rxd1, txd;
    logic        ucon, pair, ovr, rx_ptr;

    // Write enables (full address compare)
    logic we_th, we_tl, we_tcon, we_led, we_digi, we_txd, we_ucon;
    assign we_th   = wr && (addr == A_TH);
    assign we_tl   = wr && (addr == A_TL);
    assign we_tcon = wr && (addr == A_TCON);
    assign we_led  = wr && (addr == A_LED);
    assign we_digi = wr && (addr == A_DIGI);
    assign we_txd  = wr && (addr == A_TXD);
    assign we_ucon = wr && (addr == A_UCON);

    // A status read is also the clear-on-read strobe for pair/ovr.
    logic ustat_rd;
    assign ustat_rd = rd && (addr == A_USTAT);

    // Timer overflow this cycle, and whether it raises the IRQ status bit.
    logic ovf, irq_set;
    assign ovf     = tcon[0] && (tl == 32'hFFFF_FFFF);
    assign irq_set = ovf && tcon[1];

    // Pair flag as seen by an arriving byte: a same-cycle status read clears first.
    logic pair_eff;
    assign pair_eff = pair && !ustat_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th       <= '0;
            tl       <= '0;
            tcon     <= '0;
            led      <= '0;
            digi     <= '0;
            rxd0     <= '0;
            rxd1     <= '0;
            txd      <= '0;
            ucon     <= 1'b0;
            pair     <= 1'b0;
            ovr      <= 1'b0;
            rx_ptr   <= 1'b0;
            tx_start <= 1'b0;
        end else begin
            // Timer: a software TL write beats the count/reload.
            if (we_th) th <= wdata;
            if (we_tl)            tl <= wdata;
            else if (ovf)         tl <= th;
            else if (tcon[0])     tl <= tl + 32'd1;
            // Hardware set of the IRQ status bit is never lost to a write.
            if (we_tcon)          tcon <= {wdata[2] | irq_set, wdata[1:0]};
            else if (irq_set)     tcon[2] <= 1'b1;

            if (we_led)  led  <= wdata[7:0];
            if (we_digi) digi <= wdata[11:0];
            if (we_txd)  txd  <= wdata[7:0];
            if (we_ucon) ucon <= wdata[0];

            // Launch only on a 0->1 UCON write while the transmitter is idle.
            tx_start <= we_ucon && wdata[0] && !ucon && !tx_busy;

            // UART RX pairing; later assignments override the read-clear.
            if (ustat_rd) begin
                pair <= 1'b0;
                ovr  <= 1'b0;
            end
            if (rx_valid) begin
                if (pair_eff) begin
                    ovr <= 1'b1;
                end else if (!rx_ptr) begin
                    rxd0   <= rx_data;
                    rx_ptr <= 1'b1;
                end else begin
                    rxd1   <= rx_data;
                    rx_ptr <= 1'b0;
                    pair   <= 1'b1;
                end
            end
        end
    end

    assign irqout  = tcon[1] & tcon[2];
    assign tx_data = txd;

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                A_TH:    rdata = th;
                A_TL:    rdata = tl;
                A_TCON:  rdata = {29'd0, tcon};
                A_LED:   rdata = {24'd0, led};
                A_SW:    rdata = {24'd0, switch};
                A_DIGI:  rdata = {20'd0, digi};
                A_RXD0:  rdata = {24'd0, rxd0};
                A_RXD1:  rdata = {24'd0, rxd1};
                A_USTAT: rdata = {29'd0, tx_busy, ovr, pair};
                A_TXD:   rdata = {24'd0, txd};
                A_UCON:  rdata = {31'd0, ucon};
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bus.sv
module tb_peripheral_bus;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic [7:0]  led, switch, tx_data, rx_data;
    logic [11:0] digi;
    logic        irqout, tx_start, tx_busy, rx_valid;

    int errors = 0;
    int checks = 0;

    peripheral_bus #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .led(led), .switch(switch), .digi(digi), .irqout(irqout),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    // Reference model: registers as plain variables; RX tracked as a count of
    // bytes held in the current pair (0..2).
    logic [31:0] m_th, m_tl;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led, m_txd;
    logic [11:0] m_digi;
    logic [7:0]  m_rx [2];
    int          m_got;
    logic        m_ovr, m_ucon, m_txs;

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_txd = 0; m_digi = 0;
        m_rx[0] = 0; m_rx[1] = 0; m_got = 0; m_ovr = 0; m_ucon = 0; m_txs = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == BASE + 32'h00) return m_th;
        if (a == BASE + 32'h04) return m_tl;
        if (a == BASE + 32'h08) return {29'd0, m_tcon};
        if (a == BASE + 32'h0C) return {24'd0, m_led};
        if (a == BASE + 32'h10) return {24'd0, switch};
        if (a == BASE + 32'h14) return {20'd0, m_digi};
        if (a == BASE + 32'h18) return {24'd0, m_rx[0]};
        if (a == BASE + 32'h1C) return {24'd0, m_rx[1]};
        if (a == BASE + 32'h20) return {29'd0, tx_busy, m_ovr, m_got == 2};
        if (a == BASE + 32'h24) return {24'd0, m_txd};
        if (a == BASE + 32'h28) return {31'd0, m_ucon};
        return 32'd0;
    endfunction

    // Apply one clock edge of the spec's rules to the model using current inputs.
    task automatic model_clock();
        logic [31:0] ntl;
        logic [2:0]  ntc;
        bit wrap;
        wrap = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        ntl = m_tl;
        if (m_tcon[0]) ntl = wrap ? m_th : m_tl + 1;
        ntc = m_tcon;
        m_txs = wr && addr == BASE + 32'h28 && wdata[0] && !m_ucon && !tx_busy;
        if (wr) begin
            if (addr == BASE + 32'h00) m_th = wdata;
            if (addr == BASE + 32'h04) ntl = wdata;
            if (addr == BASE + 32'h08) ntc = wdata[2:0];
            if (addr == BASE + 32'h0C) m_led = wdata[7:0];
            if (addr == BASE + 32'h14) m_digi = wdata[11:0];
            if (addr == BASE + 32'h24) m_txd = wdata[7:0];
            if (addr == BASE + 32'h28) m_ucon = wdata[0];
        end
        if (wrap && m_tcon[1]) ntc[2] = 1'b1;
        m_tl = ntl;
        m_tcon = ntc;
        if (rd && addr == BASE + 32'h20) begin
            if (m_got == 2) m_got = 0;
            m_ovr = 0;
        end
        if (rx_valid) begin
            if (m_got == 2) m_ovr = 1;
            else begin
                m_rx[m_got] = rx_data;
                m_got++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic step();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        wr = 1; addr = a; wdata = d;
        step();
        wr = 0; addr = 0; wdata = 0;
    endtask

    task automatic lw(input logic [31:0] a, input logic [31:0] exp, input string tag);
        rd = 1; addr = a;
        #1 chk(tag, rdata, exp);
        step();
        rd = 0; addr = 0;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_valid = 1; rx_data = b;
        step();
        rx_valid = 0; rx_data = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".led"}, {24'd0, led}, {24'd0, m_led});
        chk({tag, ".digi"}, {20'd0, digi}, {20'd0, m_digi});
        chk({tag, ".irq"}, {31'd0, irqout}, {31'd0, m_tcon[1] & m_tcon[2]});
        chk({tag, ".txd"}, {24'd0, tx_data}, {24'd0, m_txd});
        chk({tag, ".txs"}, {31'd0, tx_start}, {31'd0, m_txs});
    endtask

    initial begin
        reset = 0; rd = 0; wr = 0; addr = 0; wdata = 0; switch = 0;
        tx_busy = 0; rx_data = 0; rx_valid = 0;
        model_reset();
        @(negedge clk);
        rd = 1; addr = BASE + 32'h10;
        #1 chk("reset.rdata_sw0", rdata, 32'd0);
        chk("reset.irq", {31'd0, irqout}, 32'd0);
        chk("reset.txs", {31'd0, tx_start}, 32'd0);
        rd = 0; addr = 0;
        @(negedge clk);
        reset = 1;

        // 1: timer overflow + reload + IRQ
        sw(BASE + 32'h00, 32'hFFFF_FFFD);
        sw(BASE + 32'h04, 32'hFFFF_FFFE);
        sw(BASE + 32'h08, 32'h3);
        step();
        lw(BASE + 32'h04, 32'hFFFF_FFFF, "t1.tl_max");
        chk("t1.irq", {31'd0, irqout}, 32'd1);
        lw(BASE + 32'h04, 32'hFFFF_FFFD, "t1.tl_reload");

        // 2: TCON write on the overflow edge keeps the status bit
        step();
        sw(BASE + 32'h08, 32'h1);
        chk("t2.irq", {31'd0, irqout}, 32'd0);
        lw(BASE + 32'h08, 32'h5, "t2.tcon");
        sw(BASE + 32'h08, 32'h0);

        // 3: RX pairing and overrun
        rx(8'h24);
        rx(8'h3C);
        lw(BASE + 32'h18, 32'h24, "t3.rxd0");
        lw(BASE + 32'h1C, 32'h3C, "t3.rxd1");
        rx(8'h11);
        lw(BASE + 32'h20, 32'h3, "t3.ustat_ovr");
        lw(BASE + 32'h18, 32'h24, "t3.rxd0_hold");
        lw(BASE + 32'h1C, 32'h3C, "t3.rxd1_hold");
        lw(BASE + 32'h20, 32'h0, "t3.ustat_clr");

        // 4: TX launch rules
        sw(BASE + 32'h24, 32'h0C);
        chk("t4.tx_data", {24'd0, tx_data}, 32'h0C);
        sw(BASE + 32'h28, 32'h1);
        chk("t4.start", {31'd0, tx_start}, 32'd1);
        step();
        chk("t4.start_1cyc", {31'd0, tx_start}, 32'd0);
        sw(BASE + 32'h28, 32'h1);
        chk("t4.no_retrig", {31'd0, tx_start}, 32'd0);
        sw(BASE + 32'h28, 32'h0);
        tx_busy = 1;
        sw(BASE + 32'h28, 32'h1);
        chk("t4.busy_ignored", {31'd0, tx_start}, 32'd0);
        lw(BASE + 32'h20, 32'h4, "t4.ustat_busy");
        tx_busy = 0;
        lw(BASE + 32'h28, 32'h1, "t4.ucon");

        // 5: switches, unmapped, LED width
        switch = 8'hA5;
        lw(BASE + 32'h10, 32'hA5, "t5.switch");
        lw(BASE + 32'h30, 32'h0, "t5.unmapped");
        sw(BASE + 32'h0C, 32'h1FF);
        chk("t5.led", {24'd0, led}, 32'hFF);
        sw(32'h5000_000C, 32'h12);
        chk("t5.led_alias", {24'd0, led}, 32'hFF);
        sw(BASE + 32'h14, 32'hFFFF);
        chk("t5.digi", {20'd0, digi}, 32'hFFF);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            a = ($urandom_range(0, 15) == 0) ? $urandom : BASE + 4 * $urandom_range(0, 11);
            switch = 8'($urandom);
            tx_busy = ($urandom_range(0, 3) == 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data = 8'($urandom);
            rd = (op < 4);
            wr = (op >= 4 && op < 8);
            addr = a;
            wdata = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if (a == BASE + 32'h08) wdata = 32'($urandom_range(0, 7));
            #1;
            if (rd) chk("rand.rdata", rdata, model_read(a));
            chk_outputs("rand");
            step();
        end
        rd = 0; wr = 0; rx_valid = 0; tx_busy = 0; addr = 0;

        // 6: asynchronous reset mid-count and mid-pair
        sw(BASE + 32'h08, 32'h3);
        sw(BASE + 32'h0C, 32'h5A);
        step();
        step();
        rx(8'h77);
        switch = 0;
        #2 reset = 0;
        #1 chk("t6.txs", {31'd0, tx_start}, 32'd0);
        chk("t6.led", {24'd0, led}, 32'd0);
        chk("t6.irq", {31'd0, irqout}, 32'd0);
        rd = 1;
        for (int k = 0; k < 11; k++) begin
            addr = BASE + 4 * k;
            #1 chk("t6.read0", rdata, 32'd0);
        end
        rd = 0; addr = 0;
        model_reset();
        @(negedge clk);
        reset = 1;
        rx(8'h55);
        rx(8'h66);
        lw(BASE + 32'h18, 32'h55, "t6.rxd0");
        lw(BASE + 32'h1C, 32'h66, "t6.rxd1");
        lw(BASE + 32'h20, 32'h1, "t6.ustat");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
